// File: rtl/svm_pkg.sv
// svm_pkg: shared defaults, quantized feature type and range limits for the
// SVM feature path.
package svm_pkg;

  localparam int NBITS_DEF     = 5;
  localparam int F_WIDTH_DEF   = 214;
  localparam int RAW_WIDTH_DEF = 16;
  localparam int SHIFT_DEF     = 6;

  typedef logic signed [NBITS_DEF-1:0] feat_t;

  localparam feat_t QMIN = feat_t'(-(2 ** (NBITS_DEF - 1)));
  localparam feat_t QMAX = feat_t'((2 ** (NBITS_DEF - 1)) - 1);

endpackage

// File: rtl/feature_quantize.sv
// feature_quantize: arithmetic right shift of a raw signed feature word,
// followed by a saturating clamp to NBITS when SVM_FEATURE_SAT_EN is defined,
// or a plain two's-complement truncation to NBITS otherwise.
module feature_quantize #(
  parameter int RAW_WIDTH = 16,
  parameter int NBITS     = 5,
  parameter int SHIFT     = 6
) (
  input  logic signed [RAW_WIDTH-1:0] i_raw,
  output logic signed [NBITS-1:0]     o_q
);

`ifdef SVM_FEATURE_SAT_EN
  localparam logic signed [RAW_WIDTH-1:0] W_LO = RAW_WIDTH'(-(2 ** (NBITS - 1)));
  localparam logic signed [RAW_WIDTH-1:0] W_HI = RAW_WIDTH'((2 ** (NBITS - 1)) - 1);

  logic signed [RAW_WIDTH-1:0] w_shifted;

  assign w_shifted = i_raw >>> SHIFT;

  // Clamp the floored value into the representable signed NBITS range.
  always_comb begin
    o_q = W_LO[NBITS-1:0];
    if (w_shifted < W_LO) begin
      o_q = W_LO[NBITS-1:0];
    end else if (w_shifted > W_HI) begin
      o_q = W_HI[NBITS-1:0];
    end else begin
      o_q = w_shifted[NBITS-1:0];
    end
  end
`else
  // Keep only the low NBITS bits of the floored value (wraps on overflow).
  assign o_q = NBITS'(i_raw >>> SHIFT);
`endif

endmodule

// File: rtl/svm_feature_loader.sv
// svm_feature_loader: collects quantized feature words into F_WIDTH-lane
// vectors held in a two-bank buffer and hands them to the classifier,
// alternating valence/arousal. Clamp vs. wrap quantization is selected by
// the SVM_FEATURE_SAT_EN macro.
module svm_feature_loader
  import svm_pkg::*;
#(
  parameter int NBITS     = NBITS_DEF,
  parameter int F_WIDTH   = F_WIDTH_DEF,
  parameter int RAW_WIDTH = RAW_WIDTH_DEF,
  parameter int SHIFT     = SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [RAW_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  output logic [NBITS*F_WIDTH-1:0]    out_features,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_is_arousal,
  output logic                        err_len
);

  localparam int VEC_W  = NBITS * F_WIDTH;
  localparam int FIDX_W = (F_WIDTH > 1) ? $clog2(F_WIDTH) : 1;
  localparam logic [FIDX_W-1:0] LAST_IDX = FIDX_W'(F_WIDTH - 1);

  logic [VEC_W-1:0]        r_bank [2];
  logic                    r_wp;
  logic                    r_rp;
  logic [1:0]              r_cnt;
  logic [FIDX_W-1:0]       r_fidx;
  logic                    r_arousal;
  logic                    r_err;

  logic signed [NBITS-1:0] w_q;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_last_lane;
  logic                    w_commit;

  feature_quantize #(
    .RAW_WIDTH (RAW_WIDTH),
    .NBITS     (NBITS),
    .SHIFT     (SHIFT)
  ) u_quant (
    .i_raw (in_data),
    .o_q   (w_q)
  );

  // Ready/valid are pure functions of occupancy, so out_ready never reaches in_ready.
  assign in_ready       = (r_cnt < 2'd2);
  assign out_valid      = (r_cnt != 2'd0);
  assign out_features   = r_bank[r_rp];
  assign out_is_arousal = r_arousal;
  assign err_len        = r_err;

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign w_last_lane = (r_fidx == LAST_IDX);
  assign w_commit    = w_in_fire && (w_last_lane || in_last);

  // Bank storage: the first word of a vector clears the rest of its bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (w_in_fire) begin
      if (r_fidx == '0) begin
        r_bank[r_wp] <= VEC_W'($unsigned(w_q));
      end else begin
        r_bank[r_wp][int'(r_fidx)*NBITS +: NBITS] <= w_q;
      end
    end else begin
      r_bank[0] <= r_bank[0];
      r_bank[1] <= r_bank[1];
    end
  end

  // Pointers, occupancy, fill index, phase bit and length-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_cnt     <= 2'd0;
      r_fidx    <= '0;
      r_arousal <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // A length fault is a commit on the last lane without in_last, or in_last early.
      r_err <= w_in_fire && (w_last_lane != in_last);

      if (w_commit) begin
        r_fidx <= '0;
        r_wp   <= ~r_wp;
      end else if (w_in_fire) begin
        r_fidx <= r_fidx + FIDX_W'(1);
      end else begin
        r_fidx <= r_fidx;
      end

      if (w_out_fire) begin
        r_rp      <= ~r_rp;
        r_arousal <= ~r_arousal;
      end else begin
        r_rp      <= r_rp;
        r_arousal <= r_arousal;
      end

      case ({w_commit, w_out_fire})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_feature_loader.sv
// tb_svm_feature_loader: directed self-checking bench for svm_feature_loader.
// Main instance uses defaults (SHIFT 6, 214 lanes); a small instance with
// SHIFT 3 and 4 lanes covers quantizer range limits. Expected quantizer
// values follow SVM_FEATURE_SAT_EN.
module tb_svm_feature_loader;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [1069:0] out_features;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_arousal;
  logic          err_len;

  logic [15:0]   s_in_data;
  logic          s_in_valid;
  logic          s_in_ready;
  logic          s_in_last;
  logic [19:0]   s_out_features;
  logic          s_out_valid;
  logic          s_out_ready;
  logic          s_out_is_arousal;
  logic          s_err_len;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  svm_feature_loader u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_last        (in_last),
    .out_features   (out_features),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_is_arousal (out_is_arousal),
    .err_len        (err_len)
  );

  svm_feature_loader #(.NBITS(5), .F_WIDTH(4), .RAW_WIDTH(16), .SHIFT(3)) u_sat (
    .clk            (clk),
    .rst            (rst),
    .in_data        (s_in_data),
    .in_valid       (s_in_valid),
    .in_ready       (s_in_ready),
    .in_last        (s_in_last),
    .out_features   (s_out_features),
    .out_valid      (s_out_valid),
    .out_ready      (s_out_ready),
    .out_is_arousal (s_out_is_arousal),
    .err_len        (s_err_len)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [4:0] lane_of(input int k);
    return out_features[k*5 +: 5];
  endfunction

  // Vector v, word k carries q = ((k + 3v) mod 32) - 16, pre-scaled by 64.
  function automatic logic [15:0] raw_of(input int v, input int k);
    int q;
    q = ((k + 3 * v) % 32) - 16;
    return 16'(q * 64);
  endfunction

  function automatic logic [4:0] exp_of(input int v, input int k);
    int q;
    q = ((k + 3 * v) % 32) - 16;
    return 5'(q);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    chk("in_ready_wait", t, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_vec(input int v, input int n, input logic with_last);
    for (int k = 0; k < n; k++) begin
      send_word(raw_of(v, k), with_last && (k == n - 1));
      if (k < n - 1) chk("err_mid", k, 32'(err_len), 32'd0);
    end
  endtask

  task automatic check_vec(input string tag, input int v, input int n);
    for (int k = 0; k < 214; k++) begin
      chk(tag, k, 32'(lane_of(k)), (k < n) ? 32'(exp_of(v, k)) : 32'd0);
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},  0, 32'(in_ready),              32'd1);
    chk({tag, "_out_valid"}, 0, 32'(out_valid),             32'd0);
    chk({tag, "_arousal"},   0, 32'(out_is_arousal),        32'd0);
    chk({tag, "_err"},       0, 32'(err_len),               32'd0);
    chk({tag, "_feat_zero"}, 0, 32'(out_features == '0),    32'd1);
  endtask

  logic [15:0] sat_raw [4];
  logic [4:0]  sat_exp [4];

  initial begin
    rst         = 1'b1;
    in_data     = 16'd0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    out_ready   = 1'b0;
    s_in_data   = 16'd0;
    s_in_valid  = 1'b0;
    s_in_last   = 1'b0;
    s_out_ready = 1'b0;
    tick();
    do_reset();
    check_reset("rst0");

    // Quantizer limits at SHIFT 3: 100->12, 200->25, -200->-25, -1->-1 before clamp/wrap.
    sat_raw[0] = 16'd100;
    sat_raw[1] = 16'd200;
    sat_raw[2] = 16'hFF38;
    sat_raw[3] = 16'hFFFF;
`ifdef SVM_FEATURE_SAT_EN
    sat_exp[0] = 5'h0C;
    sat_exp[1] = 5'h0F;
    sat_exp[2] = 5'h10;
    sat_exp[3] = 5'h1F;
`else
    sat_exp[0] = 5'h0C;
    sat_exp[1] = 5'h19;
    sat_exp[2] = 5'h07;
    sat_exp[3] = 5'h1F;
`endif
    chk("sat_in_ready", 0, 32'(s_in_ready), 32'd1);
    s_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in_data = sat_raw[i];
      s_in_last = (i == 3);
      tick();
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    chk("sat_out_valid", 0, 32'(s_out_valid), 32'd1);
    chk("sat_err", 0, 32'(s_err_len), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("sat_lane", i, 32'(s_out_features[i*5 +: 5]), 32'(sat_exp[i]));
    end

    // Ramp vector: raw k*64 quantizes to k before clamp/wrap.
    for (int k = 0; k < 214; k++) begin
      send_word(16'(k * 64), (k == 213));
      chk("ramp_err", k, 32'(err_len), 32'd0);
      if (k == 212) chk("ramp_valid_early", k, 32'(out_valid), 32'd0);
    end
    chk("ramp_valid", 0, 32'(out_valid), 32'd1);
    chk("ramp_arousal", 0, 32'(out_is_arousal), 32'd0);
    for (int k = 0; k < 214; k++) begin
`ifdef SVM_FEATURE_SAT_EN
      chk("ramp_lane", k, 32'(lane_of(k)), (k > 15) ? 32'd15 : 32'(k));
`else
      chk("ramp_lane", k, 32'(lane_of(k)), 32'(k % 32));
`endif
    end
    pop();
    chk("ramp_pop_valid", 0, 32'(out_valid), 32'd0);
    chk("ramp_pop_arousal", 0, 32'(out_is_arousal), 32'd1);

    // Back-pressure: two vectors fill the buffer, a third waits.
    do_reset();
    check_reset("rst1");
    send_vec(1, 214, 1'b1);
    chk("bp_ready_1", 0, 32'(in_ready), 32'd1);
    send_vec(2, 214, 1'b1);
    chk("bp_ready_full", 0, 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    chk("bp_ready_hold", 0, 32'(in_ready), 32'd0);
    chk("bp_valid_hold", 0, 32'(out_valid), 32'd1);
    chk("bp_arousal_a", 0, 32'(out_is_arousal), 32'd0);
    check_vec("bp_vec_a", 1, 214);
    pop();
    chk("bp_ready_rise", 0, 32'(in_ready), 32'd1);
    chk("bp_arousal_b", 0, 32'(out_is_arousal), 32'd1);
    check_vec("bp_vec_b", 2, 214);
    send_vec(3, 214, 1'b1);
    chk("bp_ready_full2", 0, 32'(in_ready), 32'd0);
    check_vec("bp_vec_b_stable", 2, 214);
    pop();
    chk("bp_arousal_c", 0, 32'(out_is_arousal), 32'd0);
    check_vec("bp_vec_c", 3, 214);
    pop();
    chk("bp_empty", 0, 32'(out_valid), 32'd0);
    chk("bp_arousal_end", 0, 32'(out_is_arousal), 32'd1);

    // Short vector: in_last on the 10th word.
    send_vec(4, 10, 1'b1);
    chk("short_err", 0, 32'(err_len), 32'd1);
    chk("short_valid", 0, 32'(out_valid), 32'd1);
    check_vec("short_vec", 4, 10);
    tick();
    chk("short_err_pulse", 0, 32'(err_len), 32'd0);
    pop();
    send_vec(5, 214, 1'b1);
    chk("after_short_err", 0, 32'(err_len), 32'd0);
    check_vec("after_short_vec", 5, 214);

    // Commit and output fire in the same cycle with one vector buffered.
    send_vec(6, 213, 1'b0);
    out_ready = 1'b1;
    send_word(raw_of(6, 213), 1'b1);
    out_ready = 1'b0;
    chk("sim_valid", 0, 32'(out_valid), 32'd1);
    chk("sim_ready", 0, 32'(in_ready), 32'd1);
    chk("sim_arousal", 0, 32'(out_is_arousal), 32'd1);
    chk("sim_err", 0, 32'(err_len), 32'd0);
    check_vec("sim_vec", 6, 214);
    pop();
    chk("sim_empty", 0, 32'(out_valid), 32'd0);

    // Long vector: 214 words without in_last commit with an error pulse.
    send_vec(7, 214, 1'b0);
    chk("long_err", 0, 32'(err_len), 32'd1);
    chk("long_valid", 0, 32'(out_valid), 32'd1);
    check_vec("long_vec", 7, 214);
    pop();
    send_vec(8, 214, 1'b1);
    chk("after_long_err", 0, 32'(err_len), 32'd0);
    chk("after_long_arousal", 0, 32'(out_is_arousal), 32'd1);
    check_vec("after_long_vec", 8, 214);

    // Reset in the middle of a vector with one vector buffered.
    send_vec(9, 100, 1'b0);
    do_reset();
    check_reset("rst_mid");
    send_vec(10, 214, 1'b1);
    chk("fresh_valid", 0, 32'(out_valid), 32'd1);
    chk("fresh_err", 0, 32'(err_len), 32'd0);
    chk("fresh_arousal", 0, 32'(out_is_arousal), 32'd0);
    check_vec("fresh_vec", 10, 214);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/svm_feature_loader.md
# svm_feature_loader

Upstream feeder for the SVM classifier. Accepts raw signed feature words one per handshake from the feature-extraction stage, quantizes each to `NBITS` (arithmetic shift then saturate), and packs `F_WIDTH` of them into one flat vector. Completed vectors sit in a two-bank buffer so the next vector can be collected while the classifier consumes the current one. Output handshake drives the classifier's `in_features`/`fin_valid`/`fin_ready` directly, alternating valence then arousal vectors.

## Interface
- `NBITS`, 5, quantized feature width (range −16..15 at default)
- `F_WIDTH`, 214, features per vector
- `RAW_WIDTH`, 16, signed raw input word width
- `SHIFT`, 6, arithmetic right-shift applied before saturation (0..RAW_WIDTH−1)

Ports:
- `clk` in 1 — single clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `in_data` in RAW_WIDTH — signed raw feature word
- `in_valid` in 1 — `in_data`/`in_last` valid
- `in_ready` out 1 — loader can accept a word
- `in_last` in 1 — marks final word of a vector
- `out_features` out NBITS*F_WIDTH — packed vector; feature k at `[k*NBITS +: NBITS]`, signed
- `out_valid` out 1 — vector available
- `out_ready` in 1 — consumer accepts vector
- `out_is_arousal` out 1 — 0: current output is the valence vector, 1: arousal vector
- `err_len` out 1 — one-cycle pulse on vector length mismatch

## Operation
- Input fire = `in_valid && in_ready`; output fire = `out_valid && out_ready`.
- State: two banks of F_WIDTH×NBITS, write pointer `wp`, read pointer `rp`, occupancy `cnt` (0..2), fill index `fidx` (0..F_WIDTH−1), phase bit.
- `in_ready = (cnt < 2)`; `out_valid = (cnt > 0)`; `out_features = bank[rp]`.
- Quantize: `q = in_data >>> SHIFT` (floor), then clamp to [−2^(NBITS−1), 2^(NBITS−1)−1]. Intermediate width RAW_WIDTH, signed.
- On input fire: write `q` to `bank[wp][fidx]`.
  - Commit condition: `fidx == F_WIDTH−1` OR `in_last`.
  - On commit: `fidx <= 0`, `wp` toggles, `cnt` increments.
  - Otherwise `fidx` increments.
- Short vector (`in_last` with `fidx < F_WIDTH−1`): lanes above `fidx` read as zero (each bank is cleared when its first word is written); commit; `err_len` pulses.
- Long vector (`fidx == F_WIDTH−1` without `in_last`): commit at F_WIDTH-th word; `err_len` pulses; the next word starts a new vector.
- On output fire: `rp` toggles, `cnt` decrements, `out_is_arousal` toggles.
- Commit and output fire in the same cycle: `cnt` unchanged; both pointers toggle.
- Reset mid-vector: partial vector discarded. `cnt`, `fidx`, `wp`, and `rp` all return to 0, and `out_is_arousal` returns to 0.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_is_arousal`=0, `err_len`=0, `out_features`=0 (banks cleared).
- Latency: a commit on input fire in cycle t gives `out_valid`=1 in cycle t+1.
- Throughput: one word per cycle. With `cnt==2`, `in_ready` drops until an output fire. `in_ready` rises the cycle after that output fire.
- `out_features` is stable while `out_valid && !out_ready`.
- `err_len` is registered and asserts in cycle t+1 for a faulty commit in cycle t.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `SVM_FEATURE_SAT_EN` defined: saturating clamp as above.
- Not defined: the shifted value is truncated to its low NBITS bits (two's-complement wrap), and no clamp logic is built. Example: raw 200, SHIFT 3 gives 25, which becomes −7.

## Structure
- Shared package `svm_pkg`:
  - `NBITS`/`F_WIDTH` defaults
  - `feat_t` (signed [NBITS-1:0])
  - `QMIN`/`QMAX` constants
- One sub-module, `feature_quantize`: combinational shift + clamp/wrap, instantiated once on the input path. Bank storage, pointers, and FSM live in the top.

## Test plan
- Reset, then 214 words (raw k·64 for k=0..213, `in_last` on word 213), SHIFT=6 → one vector; feature k = min(k,15), `out_valid` 1 cycle after last fire, `out_is_arousal`=0, `err_len` never pulses.
- Saturation at SHIFT=3: raw 100→12, 200→15, −200→−16, −1→−1. Without `SVM_FEATURE_SAT_EN`: 200→−7.
- Back-pressure: hold `out_ready`=0, stream three vectors → `in_ready` falls after the second commit. Release → vectors emerge in order with `out_is_arousal` 0,1,0.
- Short vector: `in_last` on the 10th word → `err_len` pulse; features 0..9 set, 10..213 zero. Next vector unaffected.
- Simultaneous commit and output fire with `cnt`=1 → `cnt` stays 1, the correct bank is presented, no data lost.
- Assert `rst` mid-vector (word 100) → all outputs at reset values next cycle. A fresh 214-word vector then loads cleanly.
